// File: rtl/prog_fetch_unit_pkg.sv
// Shared types and constants for the program fetch unit.
package prog_fetch_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALT
  } state_t;

  localparam logic [7:0] HALT_OP_DEF = 8'hFF;
  localparam int         PC_STRIDE   = 4;
  localparam int         PC_SHIFT    = $clog2(PC_STRIDE);

endpackage

// File: rtl/prog_fetch_unit_store.sv
// DEPTH x 8 program store: synchronous write, asynchronous read.
module prog_fetch_unit_store #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_fetch_unit.sv
// Program fetch unit: byte-loaded program store feeding the cpu one
// instruction every three cycles, addressed by the cpu PC.
module prog_fetch_unit
  import prog_fetch_unit_pkg::*;
#(
  parameter int         DEPTH   = 16,
  parameter int         AW      = 4,
  parameter logic [7:0] HALT_OP = HALT_OP_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          load_en,
  input  logic [7:0]    load_data,
  input  logic          run,
  input  logic [7:0]    pc_in,
  output logic [7:0]    INSTRUCTION,
  output logic          write_en,
  output logic [AW:0]   load_count,
  output logic          busy,
  output logic          halted,
  output logic          err
);

  state_t        state, state_d;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] idx;
  logic [7:0]    pc_hi;
  logic [7:0]    fetch_q;
  logic          oor, full;
  logic          store_we, we_d, err_set, err_clr;

  // PC is a byte address; only word-aligned PCs inside the loaded region are legal.
  assign idx   = pc_in[AW+PC_SHIFT-1:PC_SHIFT];
  assign pc_hi = pc_in >> (AW + PC_SHIFT);
  assign oor   = (pc_hi != 8'd0) || (pc_in[PC_SHIFT-1:0] != '0) ||
                 ({1'b0, idx} >= load_count);
  assign full  = (load_count == (AW+1)'(DEPTH));

  prog_fetch_unit_store #(.DEPTH(DEPTH), .AW(AW)) u_store (
    .clk   (CLK),
    .we    (store_we && !RESET),
    .waddr (wr_ptr),
    .wdata (load_data),
    .raddr (idx),
    .rdata (fetch_q)
  );

  always_comb begin
    state_d  = state;
    we_d     = 1'b0;
    err_set  = 1'b0;
    err_clr  = 1'b0;
    store_we = 1'b0;
    case (state)
      S_IDLE: begin
        store_we = load_en && !full;
        if (run) begin
          if (load_count != '0) begin
            state_d = S_FETCH;
            err_clr = 1'b1;
          end else begin
            state_d = S_HALT;
            err_set = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (!run)                     state_d = S_IDLE;
        else if (oor) begin
          state_d = S_HALT;
          err_set = 1'b1;
        end
        else if (fetch_q == HALT_OP)  state_d = S_HALT;
        else begin
          state_d = S_ISSUE;
          we_d    = 1'b1;
        end
      end
      S_ISSUE: state_d = run ? S_WAIT  : S_IDLE;
      S_WAIT:  state_d = run ? S_FETCH : S_IDLE;
      S_HALT:  if (!run) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // write_en and INSTRUCTION register on the FETCH edge, so both are valid
  // throughout the ISSUE cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      load_count  <= '0;
      INSTRUCTION <= 8'h00;
      write_en    <= 1'b0;
      err         <= 1'b0;
    end else begin
      state    <= state_d;
      write_en <= we_d;
      if (we_d) INSTRUCTION <= fetch_q;
      if (store_we) begin
        wr_ptr     <= wr_ptr + 1'b1;
        load_count <= load_count + 1'b1;
      end
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  assign busy   = (state == S_FETCH) || (state == S_ISSUE) || (state == S_WAIT);
  assign halted = (state == S_HALT);

endmodule

// File: tb/tb_prog_fetch_unit.sv
// Self-checking bench for prog_fetch_unit: scoreboard on issued instructions,
// table of single-fetch PC vectors, and hand sequences for multi-cycle cases.
module tb_prog_fetch_unit;

  logic       CLK, RESET, load_en, run;
  logic [7:0] load_data, pc_in, INSTRUCTION;
  logic       write_en, busy, halted, err;
  logic [4:0] load_count;

  int  n_cmp = 0;
  int  n_bad = 0;
  logic [7:0] exp_q [$];
  logic prev_we = 1'b0;

  prog_fetch_unit dut (
    .CLK(CLK), .RESET(RESET), .load_en(load_en), .load_data(load_data),
    .run(run), .pc_in(pc_in), .INSTRUCTION(INSTRUCTION), .write_en(write_en),
    .load_count(load_count), .busy(busy), .halted(halted), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write_en pulse must match the next queued instruction.
  always @(negedge CLK) begin
    if (write_en === 1'b1) begin
      chk("we_not_back_to_back", int'(prev_we), 0);
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_issue: got instr %0h with no expected issue", INSTRUCTION);
      end else begin
        chk("issued_instr", INSTRUCTION, exp_q.pop_front());
      end
    end
    prev_we = (write_en === 1'b1);
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; run = 1'b0; load_en = 1'b0;
    tick();
    RESET = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] b);
    load_en = 1'b1; load_data = b;
    tick();
    load_en = 1'b0;
  endtask

  // cpu model: advance PC by one instruction after every write_en pulse
  task automatic run_cpu(input int n_exp);
    int pulses = 0;
    int last   = 0;
    int cyc    = 0;
    bit gap_ok = 1'b1;
    pc_in = 8'h00; run = 1'b1;
    while (!halted && cyc < 40) begin
      tick(); cyc++;
      if (cyc == 1) chk("err_cleared_on_run", err, 0);
      if (write_en) begin
        if (pulses > 0 && cyc - last != 3) gap_ok = 1'b0;
        last = cyc; pulses++;
        pc_in = pc_in + 8'd4;
      end
    end
    chk("halt_reached", halted, 1);
    chk("pulse_count", pulses, n_exp);
    chk("pulse_gap_3", gap_ok, 1);
  endtask

  typedef struct {
    logic [7:0] pc;
    bit         issue;
    logic [7:0] instr;
    bit         e;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{8'h00, 1'b1, 8'h00, 1'b0};
    tbl[1] = '{8'h3C, 1'b1, 8'h0F, 1'b0};
    tbl[2] = '{8'h06, 1'b0, 8'h00, 1'b1};
    tbl[3] = '{8'h04, 1'b1, 8'h01, 1'b0};
    tbl[4] = '{8'h40, 1'b0, 8'h00, 1'b1};
    tbl[5] = '{8'h1C, 1'b1, 8'h07, 1'b0};
    tbl[6] = '{8'h02, 1'b0, 8'h00, 1'b1};
    tbl[7] = '{8'hFC, 1'b0, 8'h00, 1'b1};

    RESET = 1'b1; run = 1'b0; load_en = 1'b0; load_data = 8'h00; pc_in = 8'h00;
    tick(); tick();
    RESET = 1'b0;
    chk("rst_instr", INSTRUCTION, 8'h00);
    chk("rst_we", write_en, 0);
    chk("rst_load_count", load_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);

    // empty-program run
    run = 1'b1; tick();
    chk("empty_err", err, 1);
    chk("empty_halted", halted, 1);
    run = 1'b0; tick();
    chk("empty_exit_halted", halted, 0);
    chk("empty_err_sticky", err, 1);

    // three instructions then PC beyond the loaded range
    load_byte(8'h01); load_byte(8'h02); load_byte(8'h04);
    chk("lc3", load_count, 3);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h04);
    run_cpu(3);
    chk("range_err", err, 1);
    run = 1'b0; tick();

    // HALT_OP stops issue without error
    do_reset();
    load_byte(8'h02); load_byte(8'hFF); load_byte(8'h05);
    exp_q.push_back(8'h02);
    run_cpu(1);
    chk("haltop_err", err, 0);
    run = 1'b0; tick();

    // overfill: 17th byte ignored
    do_reset();
    for (int i = 0; i < 17; i++) load_byte(8'(i));
    chk("lc_full", load_count, 16);

    // single fetches, run dropped in the ISSUE cycle
    for (int i = 0; i < 8; i++) begin
      pc_in = tbl[i].pc; run = 1'b1;
      if (tbl[i].issue) exp_q.push_back(tbl[i].instr);
      tick(); tick();
      if (tbl[i].issue) chk($sformatf("v%0d_we", i), write_en, 1);
      else              chk($sformatf("v%0d_halted", i), halted, 1);
      run = 1'b0; tick();
      chk($sformatf("v%0d_idle", i), int'(busy) | int'(halted), 0);
      chk($sformatf("v%0d_err", i), err, int'(tbl[i].e));
      tick();
    end

    // reset during ISSUE
    pc_in = 8'h08; run = 1'b1;
    exp_q.push_back(8'h02);
    tick(); tick();
    chk("pre_rst_we", write_en, 1);
    RESET = 1'b1;
    tick();
    chk("midrst_we", write_en, 0);
    chk("midrst_instr", INSTRUCTION, 8'h00);
    chk("midrst_busy", busy, 0);
    chk("midrst_lc", load_count, 0);
    chk("midrst_err", err, 0);
    RESET = 1'b0; run = 1'b0;
    tick(); tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_fetch_unit.md
Name: prog_fetch_unit

Overview:
Instruction-side counterpart of the cpu core: holds a small program store, loaded byte-by-byte from the external pins. In RUN mode it uses the cpu's PC output to fetch a byte and presents it on INSTRUCTION with a one-cycle write_en strobe. Sits between the top-level I/O pins and the cpu's INSTRUCTION/write_en/PC interface.

Parameters:
DEPTH, 16, program store entries (power of two)
AW, 4, address width, log2(DEPTH)
HALT_OP, 8'hFF, opcode that stops issue; this opcode is never forwarded

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  synchronous, active-high reset
load_en  input  1  1-cycle strobe: write load_data into the store
load_data  input  8  program byte to store
run  input  1  level; 1 requests execution, 0 returns to IDLE
pc_in  input  8  cpu PC; byte address, one instruction per 4 bytes
INSTRUCTION  output  8  registered instruction to the cpu
write_en  output  1  1-cycle issue strobe to the cpu
load_count  output  AW+1  number of bytes loaded (0..DEPTH)
busy  output  1  1 while in FETCH/ISSUE/WAIT
halted  output  1  1 while in HALT
err  output  1  sticky; PC out of range or empty-program run

Behaviour:
- Reset (sync, CLK edge with RESET=1): state=IDLE, wr_ptr=0, load_count=0, INSTRUCTION=8'h00, write_en=0, busy=0, halted=0, err=0. Store contents are not cleared.
- Reset takes priority over every other input and aborts any in-flight operation, including a load.
- States: IDLE, FETCH, ISSUE, WAIT, HALT.
- IDLE:
  - load_en=1 and load_count<DEPTH: mem[wr_ptr]<=load_data; wr_ptr++; load_count++.
  - load_en=1 at load_count==DEPTH: ignored; no wrap and no overwrite.
  - run=1 and load_count>0: go to FETCH and clear err.
  - run=1 and load_count==0: set err=1 and go to HALT.
- load_en outside IDLE is ignored.
- idx = pc_in[AW+1:2].
  - Out of range when pc_in[7:AW+2]!=0, or pc_in[1:0]!=0, or idx>=load_count.
- FETCH (1 cycle):
  - Out of range: err=1, go to HALT.
  - Else read mem[idx] into fetch_q.
  - If mem[idx]==HALT_OP, go to HALT without issuing.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle): INSTRUCTION<=fetch_q and write_en=1, both registered and asserted in the same cycle. Next state is WAIT.
- WAIT (1 cycle): write_en=0, letting the cpu update its PC. Next state is FETCH.
- Issue cadence: one instruction per 3 cycles. Latency from FETCH entry to the write_en rising edge is 1 cycle.
- INSTRUCTION holds its last value between issues. write_en is never asserted for two consecutive cycles.
- run=0 in any of FETCH/ISSUE/WAIT/HALT: go to IDLE on the next edge.
  - If that cycle is ISSUE, the issue still completes: write_en stays 1 for that cycle.
- HALT: halted=1, write_en=0. Exits to IDLE only when run=0.
- busy = state in {FETCH, ISSUE, WAIT}.
- pc_in is sampled only in FETCH, so changes at any other time have no effect.

Decomposition:
- Shared package: state enum (IDLE, FETCH, ISSUE, WAIT, HALT), HALT_OP default, and constant PC_STRIDE=4.
- One natural sub-module: prog_store. It is a DEPTH x 8 memory with a synchronous write port and an asynchronous read port, indexed by AW bits.
- The FSM, load pointer and range check stay in the top module.

Test Plan:
- Reset mid-RUN: RESET=1 for 1 cycle during ISSUE -> next cycle write_en=0, INSTRUCTION=00, state IDLE, load_count=0, err=0.
- Load 3 bytes (01, 02, 04), run=1, cpu model drives pc_in 0→4→8 after each write_en -> INSTRUCTION 01, 02, 04 on successive write_en pulses 3 cycles apart. After the third issue pc_in=12 gives idx=3≥3 -> err=1, halted=1.
- Load 17 bytes (00..10) -> load_count=16 and mem[15]=0F. The 17th byte (10) is ignored and mem[0] still reads 00.
- Load 02, FF, 05, then run with pc_in 0→4 -> exactly one write_en pulse (INSTRUCTION=02). HALT_OP at idx 1 leads to halted=1 with no second pulse and err=0.
- run=1 with load_count=0 -> err=1 and halted=1 next cycle. Then run=0 -> IDLE, halted=0, err stays 1. A subsequent valid run clears err.
- Misaligned PC (pc_in=8'h06) in FETCH -> err=1, HALT, no write_en.
- Dropping run in ISSUE -> write_en high for that cycle, then IDLE, with no further pulses.
